// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider and the ALU flag mux.
package div_pkg;

  // Divider sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bit positions inside the 4-bit NZCV flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor and keep the difference only
// when it did not go negative.
module div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  // The shifted remainder needs N+1 bits; one extra bit on the difference
  // carries the borrow, whose value picks subtract or restore.
  logic [N:0]   rem_shift;
  logic [N+1:0] diff;
  logic         unused_diff_bit;

  // Trial subtraction and restore select.
  always_comb begin
    rem_shift = {rem_in, bit_in};
    diff      = {1'b0, rem_shift} - {2'b00, divisor};
    q_bit     = ~diff[N+1];
    // A kept difference is below the divisor, and a restored value is below
    // it too, so both fit in N bits.
    rem_out   = q_bit ? diff[N-1:0] : rem_shift[N-1:0];
  end

  // diff[N] is always zero whenever the difference is kept.
  assign unused_diff_bit = diff[N];

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential unsigned divider: latches an operand pair on start, resolves one
// quotient bit per clock MSB first, then presents quotient, remainder and NZCV
// flags with a one-cycle done pulse.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      q,
  output logic [N-1:0]      r,
  output logic [FLAG_W-1:0] flags
);

  localparam int             CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

  div_state_t        state_q, state_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [N-1:0]      rem_q, rem_d;
  logic [CW-1:0]     count_q, count_d;
  logic [N-1:0]      q_q, q_d;
  logic [N-1:0]      r_q, r_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  logic [N-1:0]      step_rem;
  logic              step_q_bit;
  logic [N-1:0]      q_merge;

  div_step #(.N(N)) u_step (
    .rem_in  (rem_q),
    .bit_in  (a_q[count_q]),
    .divisor (b_q),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  // Quotient with the bit resolved this cycle dropped into position count_q;
  // every other bit keeps its previous value.
  for (genvar gi = 0; gi < N; gi++) begin : g_qbit
    localparam logic [CW-1:0] IDX = CW'(gi);
    assign q_merge[gi] = (count_q == IDX) ? step_q_bit : q_q[gi];
  end

  // Next-state, operand capture, per-step update and result/flag logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    count_d = count_q;
    q_d     = q_q;
    r_d     = r_q;
    flags_d = flags_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        // DONE accepts a new request just like IDLE so operations can run
        // back to back without a dead cycle.
        if (start) begin
          a_d     = a;
          b_d     = b;
          rem_d   = '0;
          count_d = CNT_LAST;
          if (b != '0) begin
            state_d = CALC;
          end else begin
            // Divide by zero finishes immediately with a saturated quotient.
            state_d         = DONE;
            q_d             = '1;
            r_d             = a;
            flags_d         = '0;
            flags_d[FLAG_V] = 1'b1;
          end
        end
      end

      CALC: begin
        rem_d = step_rem;
        q_d   = q_merge;
        if (count_q == '0) begin
          state_d         = DONE;
          r_d             = step_rem;
          flags_d         = '0;
          flags_d[FLAG_N] = q_merge[N-1];
          flags_d[FLAG_Z] = (q_merge == '0);
          flags_d[FLAG_C] = 1'b0;
          flags_d[FLAG_V] = 1'b0;
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      count_q <= '0;
      q_q     <= '0;
      r_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      q_q     <= q_d;
      r_q     <= r_d;
      flags_q <= flags_d;
    end
  end

  assign busy  = (state_q == CALC);
  assign done  = (state_q == DONE);
  assign q     = q_q;
  assign r     = r_q;
  assign flags = flags_q;

endmodule
